// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package CPU_hazard_pkg;

    typedef enum logic {
        RUN,
        DRAIN
    } hazard_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } hazard_ctrl_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and per-stage stall/flush outputs of the hazard unit.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  ex_branch_taken;
    logic                  imem_req;
    logic                  imem_ready;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_stall;
    logic                  id_ex_flush;
    logic                  ex_mem_stall;
    logic                  mem_wb_flush;
    logic                  drain_active;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_branch_taken, imem_req, imem_ready, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, drain_active, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_branch_taken, imem_req, imem_ready, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, drain_active, stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: per-stage stall/flush generation, stale-fetch drain FSM
// and saturating stall/flush performance counters.
module hazard_ctrl
    import CPU_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic          ACLK,
    input  logic          ARESET,
    hazard_ctrl_if.slave  hif
);

    hazard_state_t state;
    hazard_state_t state_next;
    hazard_ctrl_t  ctrl;
    logic          dmem_busy;
    logic          imem_busy;
    logic          load_use;
    logic          flush_inc;

    assign dmem_busy = hif.dmem_req & ~hif.dmem_ready;
    assign imem_busy = hif.imem_req & ~hif.imem_ready;

    assign load_use = hif.ex_is_load
                    & (hif.ex_rd != REG_ADDR_W'(REG_ZERO))
                    & ((hif.id_use_rs1 & (hif.id_rs1 == hif.ex_rd))
                     | (hif.id_use_rs2 & (hif.id_rs2 == hif.ex_rd)));

    // A data-memory wait freezes everything, so branch and load-use are simply deferred.
    always_comb begin
        ctrl       = '0;
        state_next = state;
        flush_inc  = 1'b0;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    ctrl.pc_stall     = 1'b1;
                    ctrl.if_id_stall  = 1'b1;
                    ctrl.id_ex_stall  = 1'b1;
                    ctrl.ex_mem_stall = 1'b1;
                    ctrl.mem_wb_flush = 1'b1;
                end else if (hif.ex_branch_taken) begin
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    flush_inc        = 1'b1;
                    if (imem_busy) begin
                        state_next = DRAIN;
                    end
                end else if (load_use) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_stall = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end else if (imem_busy) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                end
            end
            DRAIN: begin
                // IF/ID only holds a bubble here, so it is flushed rather than stalled.
                ctrl.pc_stall    = 1'b1;
                ctrl.if_id_flush = 1'b1;
                if (dmem_busy) begin
                    ctrl.id_ex_stall  = 1'b1;
                    ctrl.ex_mem_stall = 1'b1;
                    ctrl.mem_wb_flush = 1'b1;
                end
                if (hif.imem_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (ARESET) begin
            ctrl      = '0;
            flush_inc = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    assign hif.pc_stall     = ctrl.pc_stall;
    assign hif.if_id_stall  = ctrl.if_id_stall;
    assign hif.if_id_flush  = ctrl.if_id_flush;
    assign hif.id_ex_stall  = ctrl.id_ex_stall;
    assign hif.id_ex_flush  = ctrl.id_ex_flush;
    assign hif.ex_mem_stall = ctrl.ex_mem_stall;
    assign hif.mem_wb_flush = ctrl.mem_wb_flush;
    assign hif.drain_active = (state == DRAIN);

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (ACLK),
        .rst   (ARESET),
        .inc   (ctrl.pc_stall),
        .count (hif.stall_cycles)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (ACLK),
        .rst   (ARESET),
        .inc   (flush_inc),
        .count (hif.flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle drain/stall/saturation/reset sequences.
module tb_hazard_ctrl;

    localparam int RW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          use1;
        logic          use2;
        logic [RW-1:0] rd;
        logic          is_load;
        logic          br;
        logic          ireq;
        logic          irdy;
        logic          dreq;
        logic          drdy;
    } in_t;

    // Expected control bits: {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    typedef struct {
        in_t        stim;
        logic [6:0] ctrl;
        logic       drain_next;
    } vec_t;

    typedef struct {
        logic [6:0] ctrl;
        logic       drain;
    } exp_t;

    logic ACLK = 1'b0;
    logic ARESET;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hif ();

    hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .hif    (hif.slave)
    );

    always #5 ACLK = ~ACLK;

    function automatic in_t mkIn(int rs1, int rs2, bit u1, bit u2, int rd, bit ld,
                                 bit br, bit ireq, bit irdy, bit dreq, bit drdy);
        in_t s;
        s.rs1 = RW'(rs1); s.rs2 = RW'(rs2); s.use1 = u1; s.use2 = u2;
        s.rd = RW'(rd); s.is_load = ld; s.br = br;
        s.ireq = ireq; s.irdy = irdy; s.dreq = dreq; s.drdy = drdy;
        return s;
    endfunction

    function automatic logic [6:0] dutCtrl();
        return {hif.pc_stall, hif.if_id_stall, hif.if_id_flush, hif.id_ex_stall,
                hif.id_ex_flush, hif.ex_mem_stall, hif.mem_wb_flush};
    endfunction

    task automatic checkVal(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveInputs(in_t s);
        hif.id_rs1 = s.rs1; hif.id_rs2 = s.rs2;
        hif.id_use_rs1 = s.use1; hif.id_use_rs2 = s.use2;
        hif.ex_rd = s.rd; hif.ex_is_load = s.is_load;
        hif.ex_branch_taken = s.br;
        hif.imem_req = s.ireq; hif.imem_ready = s.irdy;
        hif.dmem_req = s.dreq; hif.dmem_ready = s.drdy;
    endtask

    // Drives one cycle of inputs just after the clock edge and queues the expected response.
    task automatic applyStimulus(in_t s, logic [6:0] ctrl, logic drain);
        exp_t e;
        @(posedge ACLK);
        #1;
        driveInputs(s);
        e.ctrl  = ctrl;
        e.drain = drain;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(string name);
        exp_t e;
        @(negedge ACLK);
        if (sb_q.size() == 0) begin
            checkVal({name, " scoreboard empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            checkVal({name, " ctrl"}, int'(dutCtrl()), int'(e.ctrl));
            checkVal({name, " drain_active"}, int'(hif.drain_active), int'(e.drain));
        end
    endtask

    task automatic resetDut();
        driveInputs(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    initial begin
        in_t idle;
        in_t s;
        logic [6:0] e_idle;
        idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{idle,                                      7'b0000000, 1'b0});
        vecs.push_back('{mkIn(1, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0),     7'b1100100, 1'b0});
        vecs.push_back('{mkIn(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0),     7'b0000000, 1'b0});
        vecs.push_back('{mkIn(7, 3, 0, 1, 7, 1, 0, 0, 0, 0, 0),     7'b0000000, 1'b0});
        vecs.push_back('{mkIn(7, 3, 1, 1, 7, 0, 0, 0, 0, 0, 0),     7'b0000000, 1'b0});
        vecs.push_back('{mkIn(9, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0),     7'b1100100, 1'b0});
        vecs.push_back('{mkIn(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0),     7'b0010100, 1'b0});
        vecs.push_back('{mkIn(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0),     7'b0010100, 1'b1});
        vecs.push_back('{mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),     7'b1010000, 1'b0});
        vecs.push_back('{mkIn(1, 5, 0, 1, 5, 1, 1, 0, 0, 1, 0),     7'b1101011, 1'b0});
        vecs.push_back('{mkIn(1, 5, 0, 1, 5, 1, 0, 0, 0, 1, 1),     7'b1100100, 1'b0});
        vecs.push_back('{mkIn(1, 5, 0, 1, 5, 1, 0, 1, 0, 0, 0),     7'b1100100, 1'b0});
        vecs.push_back('{mkIn(1, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0),     7'b0010100, 1'b0});
        vecs.push_back('{mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0),     7'b1101011, 1'b0});

        ARESET = 1'b1;
        driveInputs(idle);
        #2;
        checkVal("reset ctrl", int'(dutCtrl()), 0);
        checkVal("reset drain", int'(hif.drain_active), 0);
        checkVal("reset stall_cycles", int'(hif.stall_cycles), 0);
        checkVal("reset flush_events", int'(hif.flush_events), 0);

        // Single-cycle vectors from RUN, followed by an idle cycle to observe state and counters.
        for (int i = 0; i < vecs.size(); i++) begin
            resetDut();
            applyStimulus(vecs[i].stim, vecs[i].ctrl, 1'b0);
            checkOutput($sformatf("vec%0d", i));
            e_idle = vecs[i].drain_next ? 7'b1010000 : 7'b0000000;
            applyStimulus(idle, e_idle, vecs[i].drain_next);
            checkOutput($sformatf("vec%0d next", i));
            checkVal($sformatf("vec%0d stall_cycles", i), int'(hif.stall_cycles), int'(vecs[i].ctrl[6]));
            checkVal($sformatf("vec%0d flush_events", i), int'(hif.flush_events),
                     int'(vecs[i].ctrl[4] & vecs[i].ctrl[2]));
        end

        // Load-use bubble lasts exactly one cycle once the load advances.
        resetDut();
        applyStimulus(mkIn(1, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0), 7'b1100100, 1'b0);
        checkOutput("lu cycle0");
        applyStimulus(mkIn(1, 5, 0, 1, 8, 0, 0, 0, 0, 0, 0), 7'b0000000, 1'b0);
        checkOutput("lu cycle1");
        checkVal("lu stall_cycles", int'(hif.stall_cycles), 1);

        // Redirect with a fetch in flight: three drain cycles, ready on the third.
        resetDut();
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 7'b0010100, 1'b0);
        checkOutput("drain br");
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 7'b1010000, 1'b1);
        checkOutput("drain c1");
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 7'b1010000, 1'b1);
        checkOutput("drain c2");
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 7'b1010000, 1'b1);
        checkOutput("drain c3");
        applyStimulus(idle, 7'b0000000, 1'b0);
        checkOutput("drain exit");
        checkVal("drain flush_events", int'(hif.flush_events), 1);
        checkVal("drain stall_cycles", int'(hif.stall_cycles), 3);

        // Data-memory wait holds off a pending branch and load-use for four cycles.
        resetDut();
        s = mkIn(1, 5, 0, 1, 5, 1, 1, 0, 0, 1, 0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(s, 7'b1101011, 1'b0);
            checkOutput($sformatf("dmem c%0d", c));
        end
        applyStimulus(mkIn(1, 5, 0, 1, 5, 1, 1, 0, 0, 1, 1), 7'b0010100, 1'b0);
        checkOutput("dmem release");
        checkVal("dmem stall_cycles", int'(hif.stall_cycles), 4);
        checkVal("dmem flush_events pre", int'(hif.flush_events), 0);
        applyStimulus(idle, 7'b0000000, 1'b0);
        checkOutput("dmem after");
        checkVal("dmem flush_events", int'(hif.flush_events), 1);

        // Both counters must stick at all-ones.
        resetDut();
        for (int c = 0; c < 17; c++) begin
            applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 7'b1010000, 1'b0);
            checkOutput("sat stall");
        end
        for (int c = 0; c < 17; c++) begin
            applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 7'b0010100, 1'b0);
            checkOutput("sat flush");
        end
        applyStimulus(idle, 7'b0000000, 1'b0);
        checkOutput("sat idle");
        checkVal("sat stall_cycles", int'(hif.stall_cycles), 15);
        checkVal("sat flush_events", int'(hif.flush_events), 15);

        // DRAIN with a concurrent data wait, then asynchronous reset mid-drain.
        resetDut();
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 7'b0010100, 1'b0);
        checkOutput("rst br");
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 7'b1011011, 1'b1);
        checkOutput("drain dmem");
        #2;
        ARESET = 1'b1;
        #1;
        checkVal("async rst ctrl", int'(dutCtrl()), 0);
        checkVal("async rst drain", int'(hif.drain_active), 0);
        checkVal("async rst stall_cycles", int'(hif.stall_cycles), 0);
        checkVal("async rst flush_events", int'(hif.flush_events), 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 7'b1010000, 1'b0);
        checkOutput("post rst run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
